// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for iq_stream_fifo.
//   STATUS_W        width of the status word
//   STATUS_REC_BIT  position of the recovery flag inside status
//   LEVEL_SLICE_W   number of level bits reported in status
//   level_slice()   top LEVEL_SLICE_W bits of a (depth_log2+1)-bit level
package fifo_pkg;

  localparam int unsigned STATUS_W       = 8;
  localparam int unsigned STATUS_REC_BIT = 7;
  localparam int unsigned LEVEL_SLICE_W  = STATUS_W - 1;

  // Returns level[depth_log2 : depth_log2-6]; depth_log2 must be >= 6.
  function automatic logic [LEVEL_SLICE_W-1:0] level_slice(input logic [31:0] lvl,
                                                           input int unsigned depth_log2);
    return LEVEL_SLICE_W'(lvl >> (depth_log2 - 6));
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, 2**ADDR_W x WORD_W.
//   clk      write clock
//   wr_en    write strobe, wr_data stored at wr_addr on the rising edge
//   rd_addr  read address; rd_data is combinational (show-ahead)
module fifo_ram #(
  parameter int unsigned WORD_W = 25,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/iq_stream_fifo.sv
// iq_stream_fifo: packet-aware stream FIFO with hysteresis write gating,
// optional read prefill and an optional sampled status word.
//   clk, rst            single clock, asynchronous active-high reset
//   wr_tdata/tvalid/tlast/tready   write stream (tlast stored with data)
//   rd_tdata/tlast/tvalid/tready   read stream, show-ahead head
//   level               registered occupancy
//   sample, status      status capture strobe and captured word
//   overflow            pulse after a refused wr_tvalid beat
// Build option: IQ_STREAM_FIFO_STATUS_EN enables status/recovery registers;
// without it status is constant 0 and sample is ignored.
module iq_stream_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LOW_MARK   = (2**DEPTH_LOG2) / 4,
  parameter int unsigned PREFILL    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_tdata,
  input  logic                  wr_tvalid,
  input  logic                  wr_tlast,
  output logic                  wr_tready,
  output logic [WIDTH-1:0]      rd_tdata,
  output logic                  rd_tlast,
  output logic                  rd_tvalid,
  input  logic                  rd_tready,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  sample,
  output logic [STATUS_W-1:0]   status,
  output logic                  overflow
);

  localparam int unsigned LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_L = LW'(2**DEPTH_LOG2);
  localparam logic [LW-1:0] LOW_L  = LW'(LOW_MARK);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  allow_push_q, allow_push_d;
  logic                  rd_open_q, rd_open_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, prefill_met;
  logic [WIDTH:0]        rd_word;

  if (PREFILL == 0) begin : g_no_prefill
    assign prefill_met = 1'b1;
  end else begin : g_prefill
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
    assign prefill_met = (level_q >= PREFILL_L);
  end

  always_comb begin
    wr_tready = (level_q != FULL_L) && allow_push_q;
    rd_tvalid = (level_q != '0) && (rd_open_q || prefill_met);
    push      = wr_tvalid && wr_tready;
    pop       = rd_tvalid && rd_tready;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    // Hysteresis: once full, writes stay closed until a tlast beat is
    // offered at or below LOW_MARK; that beat is dropped so the stream
    // resumes on the following packet start.
    allow_push_d = allow_push_q;
    if (level_d == FULL_L) begin
      allow_push_d = 1'b0;
    end else if (!allow_push_q && wr_tvalid && wr_tlast && (level_q <= LOW_L)) begin
      allow_push_d = 1'b1;
    end

    rd_open_d = rd_open_q;
    if (pop && (level_d == '0)) begin
      rd_open_d = 1'b0;
    end else if (prefill_met) begin
      rd_open_d = 1'b1;
    end

    overflow_d = wr_tvalid && !wr_tready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      allow_push_q <= 1'b1;
      rd_open_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      allow_push_q <= allow_push_d;
      rd_open_q    <= rd_open_d;
      overflow_q   <= overflow_d;
    end
  end

  fifo_ram #(
    .WORD_W (WIDTH + 1),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({wr_tlast, wr_tdata}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  assign rd_tdata = rd_word[WIDTH-1:0];
  assign rd_tlast = rd_word[WIDTH];
  assign level    = level_q;
  assign overflow = overflow_q;

`ifdef IQ_STREAM_FIFO_STATUS_EN
  logic [STATUS_W-1:0] status_q, status_d;
  logic                recovery_q, recovery_d;
  logic                recovery_set;

  // A set condition in the same cycle as sample keeps the flag raised,
  // so the event is reported in the following period.
  always_comb begin
    recovery_set = (rd_tready && !rd_tvalid) || !allow_push_q;
    status_d     = status_q;
    recovery_d   = recovery_q;
    if (sample) begin
      status_d[LEVEL_SLICE_W-1:0] = level_slice(32'(level_q), DEPTH_LOG2);
      status_d[STATUS_REC_BIT]    = recovery_q;
      recovery_d                  = 1'b0;
    end
    if (recovery_set) begin
      recovery_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      recovery_q <= 1'b0;
    end else begin
      status_q   <= status_d;
      recovery_q <= recovery_d;
    end
  end

  assign status = status_q;
`else
  logic unused_sample;
  assign unused_sample = sample;
  assign status        = '0;
`endif

endmodule

// File: tb/tb_iq_stream_fifo.sv
// tb_iq_stream_fifo: directed bench with a scoreboard for iq_stream_fifo.
// Two instances: dut (PREFILL=0) and dut_pf (PREFILL=64).
// Status expectations follow IQ_STREAM_FIFO_STATUS_EN.
module tb_iq_stream_fifo;

  localparam int unsigned DEPTH = 1024;
`ifdef IQ_STREAM_FIFO_STATUS_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample;

  logic [23:0] wr_tdata;
  logic        wr_tvalid, wr_tlast, wr_tready;
  logic [23:0] rd_tdata;
  logic        rd_tlast, rd_tvalid, rd_tready;
  logic [10:0] level;
  logic [7:0]  status;
  logic        overflow;

  logic [23:0] pf_wr_tdata;
  logic        pf_wr_tvalid, pf_wr_tlast, pf_wr_tready;
  logic [23:0] pf_rd_tdata;
  logic        pf_rd_tlast, pf_rd_tvalid, pf_rd_tready;
  logic [10:0] pf_level;
  logic [7:0]  pf_status;
  logic        pf_overflow;

  int checks = 0;
  int errors = 0;

  // scoreboard and spec model state for dut
  logic [24:0] sb[$];
  int          m_level;
  bit          m_allow;
  bit          m_ovf;
  logic [23:0] next_data;
  bit          acc;

  always #5 clk = ~clk;

  iq_stream_fifo #(.WIDTH(24), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tlast(wr_tlast), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tlast(rd_tlast), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
    .level(level), .sample(sample), .status(status), .overflow(overflow)
  );

  iq_stream_fifo #(.WIDTH(24), .DEPTH_LOG2(10), .PREFILL(64)) dut_pf (
    .clk(clk), .rst(rst),
    .wr_tdata(pf_wr_tdata), .wr_tvalid(pf_wr_tvalid), .wr_tlast(pf_wr_tlast), .wr_tready(pf_wr_tready),
    .rd_tdata(pf_rd_tdata), .rd_tlast(pf_rd_tlast), .rd_tvalid(pf_rd_tvalid), .rd_tready(pf_rd_tready),
    .level(pf_level), .sample(sample), .status(pf_status), .overflow(pf_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_level = 0;
    m_allow = 1'b1;
    m_ovf   = 1'b0;
  endtask

  // One cycle on dut: drive, check against the model, clock, update model.
  task automatic step(input logic v, input logic [23:0] d, input logic last,
                      input logic rr, output bit accepted);
    bit exp_ready, exp_valid, popped;
    int nl;
    wr_tvalid = v; wr_tdata = d; wr_tlast = last; rd_tready = rr;
    #1;
    exp_ready = (m_level != DEPTH) && m_allow;
    exp_valid = (m_level != 0);
    chk("wr_tready", 32'(wr_tready), 32'(exp_ready));
    chk("rd_tvalid", 32'(rd_tvalid), 32'(exp_valid));
    chk("level", 32'(level), m_level);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (exp_valid && sb.size() != 0) chk("head", 32'({rd_tlast, rd_tdata}), 32'(sb[0]));
    accepted = v && exp_ready;
    popped   = exp_valid && rr;
    @(posedge clk);
    nl    = m_level + (accepted ? 1 : 0) - (popped ? 1 : 0);
    m_ovf = v && !exp_ready;
    if (nl == DEPTH) m_allow = 1'b0;
    else if (!m_allow && v && last && m_level <= 256) m_allow = 1'b1;
    if (accepted) sb.push_back({last, d});
    if (popped) void'(sb.pop_front());
    m_level = nl;
    @(negedge clk);
  endtask

  task automatic pf_step(input logic v, input logic [23:0] d, input logic last, input logic rr);
    pf_wr_tvalid = v; pf_wr_tdata = d; pf_wr_tlast = last; pf_rd_tready = rr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_tvalid = 1'b0; wr_tdata = '0; wr_tlast = 1'b0; rd_tready = 1'b0;
    pf_wr_tvalid = 1'b0; pf_wr_tdata = '0; pf_wr_tlast = 1'b0; pf_rd_tready = 1'b0;
    sample = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1;
    wr_tvalid = 1'b0; wr_tdata = '0; wr_tlast = 1'b0; rd_tready = 1'b0;
    pf_wr_tvalid = 1'b0; pf_wr_tdata = '0; pf_wr_tlast = 1'b0; pf_rd_tready = 1'b0;
    sample = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_rd_tvalid", 32'(rd_tvalid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_pf_status", 32'(pf_status), 0);
    chk("rst_wr_tready", 32'(wr_tready), 1);
    rst = 1'b0;

    // five beats, no reads
    step(1'b1, 24'h000001, 1'b0, 1'b0, acc);
    chk("first_visible_valid", 32'(rd_tvalid), 1);
    chk("first_visible_data", 32'(rd_tdata), 32'h1);
    for (int i = 2; i <= 5; i++) step(1'b1, 24'(i), (i == 5), 1'b0, acc);
    chk("five_level", 32'(level), 5);
    step(1'b0, 24'h0, 1'b0, 1'b0, acc);
    chk("head_held", 32'(rd_tdata), 32'h1);
    next_data = 24'h000006;

    // fill to DEPTH
    for (int i = 0; i < 2000 && m_level < DEPTH; i++) begin
      step(1'b1, next_data, (next_data[3:0] == 4'h0), 1'b0, acc);
      if (acc) next_data++;
    end
    chk("full_level", 32'(level), DEPTH);
    chk("full_wr_tready", 32'(wr_tready), 0);
    step(1'b1, next_data, 1'b0, 1'b0, acc);
    chk("overflow_pulse", 32'(overflow), 1);
    step(1'b0, 24'h0, 1'b0, 1'b0, acc);
    chk("overflow_one_cycle", 32'(overflow), 0);
    step(1'b1, next_data, 1'b0, 1'b1, acc);
    chk("full_pop_level", 32'(level), DEPTH - 1);
    chk("full_push_refused", 32'(wr_tready), 0);

    // hysteresis
    for (int i = 0; i < 2000 && m_level > 300; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);
    step(1'b1, next_data, 1'b1, 1'b0, acc);
    chk("no_reopen_300", 32'(wr_tready), 0);
    for (int i = 0; i < 2000 && m_level > 256; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);
    step(1'b1, next_data, 1'b1, 1'b0, acc);
    chk("reopen_beat_dropped", 32'(level), 256);
    chk("reopened", 32'(wr_tready), 1);
    step(1'b1, next_data, 1'b0, 1'b0, acc);
    if (acc) next_data++;
    chk("after_reopen_accept", 32'(level), 257);
    for (int i = 0; i < 2000 && m_level > 0; i++) step(1'b0, 24'h0, 1'b0, 1'b1, acc);
    chk("drained_valid", 32'(rd_tvalid), 0);

    // reset mid-packet
    for (int i = 0; i < 37; i++) step(1'b1, 24'(32'h100 + i), 1'b0, 1'b0, acc);
    chk("pre_rst_level", 32'(level), 37);
    rst = 1'b1;
    #1;
    chk("async_rst_level", 32'(level), 0);
    chk("async_rst_valid", 32'(rd_tvalid), 0);
    model_reset();
    wr_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(wr_tready), 1);
    step(1'b1, 24'hABCDEF, 1'b1, 1'b0, acc);
    chk("post_rst_first_data", 32'(rd_tdata), 32'hABCDEF);
    chk("post_rst_first_last", 32'(rd_tlast), 1);
    step(1'b0, 24'h0, 1'b0, 1'b1, acc);

    // status: level slice
    do_reset();
    for (int i = 0; i < 512; i++) step(1'b1, 24'(i), 1'b0, 1'b0, acc);
    sample = 1'b1;
    step(1'b0, 24'h0, 1'b0, 1'b0, acc);
    sample = 1'b0;
    chk("status_512", 32'(status), STAT_ON ? 32'h20 : 32'h0);

    // status: recovery flag
    do_reset();
    step(1'b0, 24'h0, 1'b0, 1'b1, acc);
    sample = 1'b1;
    step(1'b0, 24'h0, 1'b0, 1'b0, acc);
    chk("status_recovery_set", 32'(status), STAT_ON ? 32'h80 : 32'h0);
    step(1'b0, 24'h0, 1'b0, 1'b0, acc);
    chk("status_recovery_clear", 32'(status), 0);
    step(1'b0, 24'h0, 1'b0, 1'b1, acc);
    chk("status_coincide", 32'(status), 0);
    step(1'b0, 24'h0, 1'b0, 1'b0, acc);
    chk("status_set_wins", 32'(status), STAT_ON ? 32'h80 : 32'h0);
    sample = 1'b0;

    // prefill instance
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= 63; i++) begin
        chk("pf_wr_tready", 32'(pf_wr_tready), 1);
        pf_step(1'b1, 24'(i), 1'b0, 1'b0);
        chk("pf_closed", 32'(pf_rd_tvalid), 0);
      end
      pf_step(1'b1, 24'd64, 1'b1, 1'b0);
      chk("pf_open", 32'(pf_rd_tvalid), 1);
      chk("pf_level", 32'(pf_level), 64);
      if (pass == 0) begin
        for (int i = 1; i <= 64; i++) begin
          chk("pf_drain_valid", 32'(pf_rd_tvalid), 1);
          chk("pf_drain_data", 32'(pf_rd_tdata), i);
          if (i == 64) chk("pf_drain_last", 32'(pf_rd_tlast), 1);
          pf_step(1'b0, 24'h0, 1'b0, 1'b1);
        end
        chk("pf_empty_valid", 32'(pf_rd_tvalid), 0);
        chk("pf_empty_level", 32'(pf_level), 0);
      end
    end
    chk("pf_overflow", 32'(pf_overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_stream_fifo.md
IQ_STREAM_FIFO -- requirements
Module: iq_stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 24: data bits per beat.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: DEPTH = 2**DEPTH_LOG2 entries.
REQ-003 SHALL have parameter LOW_MARK, default DEPTH/4: level at or below which writes are re-enabled.
REQ-004 SHALL have parameter PREFILL, default 0: level required before reads open.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- wr_tdata  in  WIDTH  write data.
- wr_tvalid  in  1  write beat offered.
- wr_tlast  in  1  last beat of packet; stored with the data.
- wr_tready  out  1  write beat accepted this cycle.
- rd_tdata  out  WIDTH  head data, show-ahead.
- rd_tlast  out  1  head tlast.
- rd_tvalid  out  1  head valid.
- rd_tready  in  1  pop request.
- level  out  DEPTH_LOG2+1  registered occupancy.
- sample  in  1  status capture strobe.
- status  out  8  {recovery, level[DEPTH_LOG2:DEPTH_LOG2-6]}.
- overflow  out  1  one-cycle pulse when a wr_tvalid beat is refused.

Function
REQ-006 A push SHALL occur iff wr_tvalid and wr_tready; a pop SHALL occur iff rd_tvalid and rd_tready.
REQ-007 wr_tready SHALL equal (level != DEPTH) and allow_push.
REQ-008 allow_push SHALL clear on the edge where level becomes DEPTH.
REQ-009 allow_push SHALL set on an edge where wr_tvalid, wr_tlast and level <= LOW_MARK all hold; that beat is not accepted.
- The next beat is accepted.
- Writes therefore resume on a packet boundary.
REQ-010 Storage SHALL be first-in first-out. Pointers are DEPTH_LOG2 bits, wrap modulo DEPTH and carry no reset-time wrap ambiguity.
REQ-011 Occupancy SHALL be counted as follows:
- level +1 on push only, -1 on pop only.
- Unchanged on simultaneous push and pop.
REQ-012 A pushed beat SHALL be visible at rd_tdata/rd_tlast with rd_tvalid high on the cycle after the push edge, when the FIFO was empty and PREFILL <= 1.
REQ-013 rd_tvalid SHALL equal (level != 0) and (rd_open or level >= PREFILL).
- rd_open sets when level >= PREFILL.
- rd_open clears on the edge a pop leaves level 0.
REQ-014 When full, a simultaneous pop SHALL proceed and the push SHALL be refused, because wr_tready is derived from registered level.
REQ-015 When empty, a push SHALL proceed and no pop occurs.
REQ-016 overflow SHALL pulse on the edge after any cycle with wr_tvalid high and wr_tready low.
REQ-017 rd_tdata and rd_tlast SHALL be held stable while rd_tvalid is high and rd_tready is low.

Reset
REQ-018 rst SHALL asynchronously force the following; all stored contents are discarded:
- pointers = 0, level = 0, allow_push = 1, rd_open = 0.
- rd_tvalid = 0, overflow = 0, status = 0, recovery flag = 0.
REQ-019 Assertion mid-packet SHALL discard the partial packet. After deassertion, wr_tready SHALL be 1 on the first cycle.

Configuration
REQ-020 With macro IQ_STREAM_FIFO_STATUS_EN defined, status SHALL behave as follows:
- On sample, status[6:0] loads level[DEPTH_LOG2:DEPTH_LOG2-6] and status[7] loads the recovery flag.
- The recovery flag SHALL clear on sample.
- The recovery flag SHALL set on any cycle with rd_tready and not rd_tvalid, or with allow_push low.
- When a set condition coincides with sample, the set wins for the next period.
REQ-021 Without IQ_STREAM_FIFO_STATUS_EN, status SHALL be constant 0, sample SHALL be ignored and no status registers SHALL be synthesised.

Structure
REQ-022 The following SHALL live in package fifo_pkg:
- STATUS_W = 8.
- Recovery bit index 7.
- A level-slice helper function.
REQ-023 Storage SHALL be one sub-module, fifo_ram: simple dual-port, DEPTH x (WIDTH+1), write-synchronous, show-ahead read at the head pointer.

Verification
REQ-024 Bench SHALL cover:
- Reset, then push 5 beats (0x000001..0x000005) with rd_tready=0 -> level=5; rd_tvalid high from cycle 1 after first push; rd_tdata=0x000001 held.
- Fill DEPTH=1024 -> wr_tready=0 at level 1024; next wr_tvalid -> overflow pulse. Simultaneous pop at full -> level 1023, push refused.
- Drain from full to 256, then offer a wr_tlast beat -> allow_push=1; that beat is not accepted; the next beat is accepted. Drain to 300 -> a wr_tlast beat does not reopen.
- PREFILL=64: pushes 1..63 -> rd_tvalid=0; 64th push -> rd_tvalid=1. Drain to 0 -> rd_tvalid=0 until level is 64 again.
- With IQ_STREAM_FIFO_STATUS_EN, level=512 and sample -> status=0x20. rd_tready while empty, then sample -> status[7]=1; next clean sample -> status[7]=0. Without the macro -> status=0.
- rst asserted mid-packet at level 37 -> level=0, rd_tvalid=0 immediately; after release wr_tready=1 and the first new beat reads out first.
